// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO feeding a UART transmitter. Writes go into a
//               DEPTH x 8 circular buffer. A three-state handshake FSM
//               (IDLE/STROBE/DRAIN) pops the head byte onto tx_byte and
//               raises stb. It then waits for the transmitter to go busy
//               (tx_rdy low) and become idle again before it pops the next
//               byte.
// Ports       : clk      - single clock, rising edge
//               res      - synchronous active-high reset
//               wr_data  - byte to enqueue
//               wr_en    - enqueue request (one byte per cycle)
//               full     - FIFO holds DEPTH bytes (registered)
//               empty    - FIFO holds 0 bytes (registered)
//               count    - occupancy 0..DEPTH (registered)
//               overflow - sticky; set by a write attempted while full
//               tx_byte  - byte presented to the transmitter
//               stb      - strobe; transmitter captures tx_byte on its rise
//               tx_rdy   - transmitter idle and able to accept a byte
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    tx_byte,
  output logic          stb,
  input  logic          tx_rdy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic [7:0]    r_tx_byte;
  logic          r_stb;
  state_t        r_state;

  state_t        w_state_next;
  logic          w_pop;
  logic          w_stb_next;
  logic          w_wr_acc;
  logic [AW:0]   w_count_next;

  // The full flag already reflects last cycle's pops, so a write that meets
  // full=1 is dropped even if a pop happens on the same edge.
  assign w_wr_acc     = wr_en & ~r_full;
  assign w_count_next = r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_pop);

  // Transmit FSM: next state and registered-output next values
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_stb_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && tx_rdy) begin
          w_pop        = 1'b1;
          w_stb_next   = 1'b1;
          w_state_next = S_STROBE;
        end
      end
      S_STROBE: begin
        // Strobe is held until the transmitter reports busy.
        w_stb_next = 1'b1;
        if (!tx_rdy) begin
          w_stb_next   = 1'b0;
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tx_rdy) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pointers, occupancy, flags and transmitter outputs
  always_ff @(posedge clk) begin
    if (res) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
      r_stb     <= 1'b0;
      r_tx_byte <= 8'h00;
    end else begin
      r_stb <= w_stb_next;
      if (w_pop) begin
        r_tx_byte <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == c_FULL_CNT);
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Storage array; no reset needed because occupancy tracking guards reads.
  always_ff @(posedge clk) begin
    if (!res && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;
  assign overflow = r_ovf;
  assign tx_byte  = r_tx_byte;
  assign stb      = r_stb;

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in bytes; SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default $clog2(DEPTH): pointer width, derived from DEPTH and not overridden.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 res  input  1: reset, synchronous and active-high.
REQ-005 wr_data  input  8: byte to enqueue.
REQ-006 wr_en  input  1: enqueue request, one byte per cycle asserted.
REQ-007 full  output  1: FIFO holds DEPTH bytes.
REQ-008 empty  output  1: FIFO holds 0 bytes.
REQ-009 count  output  AW+1: current occupancy, 0..DEPTH.
REQ-010 overflow  output  1: sticky flag, set by a write attempted while full.
REQ-011 tx_byte  output  8: byte presented to the downstream transmitter.
REQ-012 stb  output  1: strobe to the transmitter; the transmitter captures tx_byte on the rising edge of stb.
REQ-013 tx_rdy  input  1: transmitter idle and able to accept a byte.

Function
REQ-014 Storage SHALL be a DEPTH x 8 circular buffer with AW-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-015 Write accepted: wr_en=1 and full=0 -> store wr_data at the write pointer; increment the write pointer.
REQ-016 Write while full: the byte SHALL be dropped, no state changes, and overflow SHALL be set the next cycle.
REQ-017 A write while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-018 Pop and accepted write in the same cycle: count SHALL be unchanged and both pointers SHALL advance.
REQ-019 full, empty and count SHALL be registered and SHALL reflect all writes and pops of the previous cycle.
REQ-020 Transmit FSM states: IDLE, STROBE, DRAIN.
REQ-021 IDLE, with empty=0 and tx_rdy=1: load tx_byte from the head entry, pop it (read pointer +1, count -1), set stb=1, go to STROBE.
REQ-022 IDLE, any other condition: stb=0, tx_byte held, remain in IDLE.
REQ-023 STROBE: hold stb=1 and hold tx_byte until tx_rdy=0 is sampled, then set stb=0 and go to DRAIN.
REQ-024 DRAIN: stb=0; on tx_rdy=1 go to IDLE.
REQ-025 No byte SHALL be popped in STROBE or DRAIN.
REQ-026 tx_byte SHALL be stable from the cycle stb rises until the cycle stb falls.
REQ-027 Latency: write into an empty FIFO at cycle N with the FSM in IDLE and tx_rdy=1 -> stb=1 and tx_byte=that byte at cycle N+2.
REQ-028 Ordering: bytes SHALL reach tx_byte in write order; no byte is lost or duplicated unless it was dropped on overflow.
REQ-029 The minimum spacing between consecutive stb rising edges SHALL be 3 cycles (STROBE, DRAIN, IDLE).
REQ-030 overflow SHALL be cleared only by res.

Reset
REQ-031 res=1 sampled on a clock edge: pointers=0, count=0, empty=1, full=0, overflow=0, stb=0, tx_byte=8'h00, FSM=IDLE.
REQ-032 res SHALL take priority over wr_en and over FSM activity in the same cycle.
REQ-033 Reset mid-STROBE: stb SHALL fall on the next edge, and the in-flight byte and all buffered bytes SHALL be discarded.
REQ-034 After res deasserts, the first write SHALL be accepted in the same cycle.

Verification
REQ-035 Single byte: with tx_rdy=1, write 8'hA5 at cycle N -> stb=1 and tx_byte=A5 at N+2; drive tx_rdy=0 at N+4 -> stb=0 at N+5; empty=1 throughout after N+2.
REQ-036 Ordering: write 8'h01..8'h10 back-to-back with the transmitter model answering each strobe -> 16 strobes observed carrying 01..10 in order, with no overflow.
REQ-037 Full/overflow (DEPTH=16, tx_rdy=0): 17 writes -> full=1 and count=16 after the 16th; overflow=1 after the 17th; the drained sequence excludes the 17th byte.
REQ-038 Simultaneous write and pop at count=3 -> count stays 3; the popped and written bytes keep correct order across a pointer wrap (write pointer 15 -> 0).
REQ-039 Reset with stb=1, count=5, overflow=1 -> the next cycle shows stb=0, count=0, empty=1, overflow=0, tx_byte=00.
REQ-040 tx_rdy held low in IDLE with count>0 -> stb stays 0 and count is unchanged until tx_rdy=1.
